// File: rtl/gpio_in_debounce_pkg.sv
// Shared helpers and default sizing for the GPIO input debounce slice.
package gpio_in_debounce_pkg;

    localparam int unsigned IO_NUM_MAX = 32;

    // Ceiling log2 evaluated at elaboration; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One pad bit: synchroniser, tick-driven debounce counter, level register, edge pulses.
module gpio_db_bit
    import gpio_in_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_TICKS   = 8,
    parameter logic        INIT_BIT    = 1'b0
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic EN,
    input  logic tick,
    input  logic pad,
    output logic db,
    output logic rise,
    output logic fall,
    output logic accept_c
);

    localparam int unsigned CNT_W = clog2(DEB_TICKS + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   db_d;

    // Synchroniser keeps running while EN is low so re-enable sees a settled level.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_q <= {SYNC_STAGES{INIT_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d    = cnt_q;
        db_d     = db;
        accept_c = 1'b0;
        if (!EN) begin
            cnt_d = '0;
        end else if (s == db) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
                db_d     = s;
                cnt_d    = '0;
                accept_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
            db    <= INIT_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db    <= db_d;
            rise  <= accept_c & s;
            fall  <= accept_c & ~s;
        end
    end

endmodule

// File: rtl/gpio_in_debounce.sv
// Pad conditioning ahead of CoreGPIO GPIO_IN: shared prescaler, per-bit debounce, change flag.
module gpio_in_debounce
    import gpio_in_debounce_pkg::*;
#(
    parameter int unsigned       IO_NUM      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       TICK_DIV    = 1000,
    parameter int unsigned       DEB_TICKS   = 8,
    parameter logic [IO_NUM-1:0] INIT_VAL    = '0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              EN,
    input  logic [IO_NUM-1:0] PAD_IN,
    output logic [IO_NUM-1:0] GPIO_DB,
    output logic [IO_NUM-1:0] RISE,
    output logic [IO_NUM-1:0] FALL,
    output logic              CHANGED
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic              tick_c;
    logic [IO_NUM-1:0] accept_c;

    // Prescaler parks at zero while disabled so every enable starts from a fresh phase.
    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        tick_c = 1'b0;
        if (!EN) begin
            pre_d = '0;
        end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
            pre_d  = '0;
            tick_c = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
        gpio_db_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_TICKS   (DEB_TICKS),
            .INIT_BIT    (INIT_VAL[i])
        ) u_bit (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .EN       (EN),
            .tick     (tick_c),
            .pad      (PAD_IN[i]),
            .db       (GPIO_DB[i]),
            .rise     (RISE[i]),
            .fall     (FALL[i]),
            .accept_c (accept_c[i])
        );
    end

    // Registered from the same acceptance term so it lines up with RISE/FALL.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            CHANGED <= 1'b0;
        end else begin
            CHANGED <= |accept_c;
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce: expected acceptance events are queued at stimulus time.
module tb_gpio_in_debounce;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       EN;
    logic [3:0] PAD_IN;
    logic [3:0] GPIO_DB;
    logic [3:0] RISE;
    logic [3:0] FALL;
    logic       CHANGED;

    typedef struct {
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
        int         lo;
        int         hi;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    gpio_in_debounce #(
        .IO_NUM      (4),
        .SYNC_STAGES (2),
        .TICK_DIV    (4),
        .DEB_TICKS   (3),
        .INIT_VAL    (4'b1000)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .EN      (EN),
        .PAD_IN  (PAD_IN),
        .GPIO_DB (GPIO_DB),
        .RISE    (RISE),
        .FALL    (FALL),
        .CHANGED (CHANGED)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Acceptance window is 11..14 edges after the stimulus edge for this configuration.
    task automatic expect_ev(input logic [3:0] db, input logic [3:0] rise, input logic [3:0] fall);
        ev_t e;
        e.db   = db;
        e.rise = rise;
        e.fall = fall;
        e.lo   = cyc + 11;
        e.hi   = cyc + 14;
        exp_q.push_back(e);
    endtask

    // Any pulse activity must match the oldest queued event; otherwise it is spurious.
    always @(negedge PCLK) begin : mon
        ev_t e;
        if (RISE != 4'b0 || FALL != 4'b0 || CHANGED) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 32'({RISE, FALL, CHANGED}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ev_db",      32'(GPIO_DB), 32'(e.db));
                check("ev_rise",    32'(RISE),    32'(e.rise));
                check("ev_fall",    32'(FALL),    32'(e.fall));
                check("ev_changed", 32'(CHANGED), 32'd1);
                check("ev_latency", (cyc >= e.lo && cyc <= e.hi) ? 32'(e.lo) : 32'(cyc), 32'(e.lo));
            end
        end
    end

    initial begin
        PRESET = 1'b1;
        EN     = 1'b1;
        PAD_IN = 4'b1000;
        step(3);
        PRESET = 1'b0;
        check("rst_db",      32'(GPIO_DB), 32'h8);
        check("rst_rise",    32'(RISE),    32'h0);
        check("rst_fall",    32'(FALL),    32'h0);
        check("rst_changed", 32'(CHANGED), 32'h0);

        // 1: INIT_VAL held on the pads produces no activity
        for (int i = 0; i < 4; i++) begin
            step(10);
            check("t1_db", 32'(GPIO_DB), 32'h8);
        end

        // 2: single-bit rise
        PAD_IN = 4'b1001;
        expect_ev(4'b1001, 4'b0001, 4'b0000);
        step(20);
        check("t2_pending", 32'(exp_q.size()), 32'd0);
        check("t2_db",      32'(GPIO_DB),      32'h9);

        // 3: short glitch rejected, long hold accepted both ways
        PAD_IN = 4'b1011;
        step(6);
        PAD_IN = 4'b1001;
        step(20);
        check("t3_glitch_db", 32'(GPIO_DB), 32'h9);
        PAD_IN = 4'b1011;
        expect_ev(4'b1011, 4'b0010, 4'b0000);
        step(20);
        PAD_IN = 4'b1001;
        expect_ev(4'b1001, 4'b0000, 4'b0010);
        step(20);
        check("t3_pending", 32'(exp_q.size()), 32'd0);
        check("t3_db",      32'(GPIO_DB),      32'h9);

        // 4: return to 1000, then a multi-bit rise/fall in one cycle
        PAD_IN = 4'b1000;
        expect_ev(4'b1000, 4'b0000, 4'b0001);
        step(20);
        PAD_IN = 4'b0101;
        expect_ev(4'b0101, 4'b0101, 4'b1000);
        step(20);
        check("t4_db", 32'(GPIO_DB), 32'h5);
        PAD_IN = 4'b1000;
        expect_ev(4'b1000, 4'b1000, 4'b0101);
        step(20);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // 5: EN dropped mid-debounce; full debounce restarts on re-enable
        PAD_IN = 4'b1100;
        step(6);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t5_hold_db", 32'(GPIO_DB), 32'h8);
        end
        check("t5_pending_off", 32'(exp_q.size()), 32'd0);
        EN = 1'b1;
        expect_ev(4'b1100, 4'b0100, 4'b0000);
        step(20);
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        check("t5_db",      32'(GPIO_DB),      32'hC);

        // 6: reset while bit 3 is mid-count
        PAD_IN = 4'b0100;
        step(7);
        check("t6_pre_db", 32'(GPIO_DB), 32'hC);
        PRESET = 1'b1;
        step(1);
        PRESET = 1'b0;
        check("t6_rst_db",      32'(GPIO_DB), 32'h8);
        check("t6_rst_rise",    32'(RISE),    32'h0);
        check("t6_rst_fall",    32'(FALL),    32'h0);
        check("t6_rst_changed", 32'(CHANGED), 32'h0);
        expect_ev(4'b0100, 4'b0100, 4'b1000);
        step(20);
        check("t6_pending", 32'(exp_q.size()), 32'd0);
        check("t6_db",      32'(GPIO_DB),      32'h4);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
Input conditioning stage that sits directly upstream of the CoreGPIO instance. It drives that instance's GPIO_IN bus from raw board pads such as push-buttons and switches. Each bit is synchronised into the PCLK domain, debounced against a shared prescaled tick, and the stable level is presented downstream. Single-cycle rise and fall strobes are also produced for logic that needs edge events without going through APB interrupts.

Parameters:
IO_NUM, 8, number of pad bits (1..32); matches CoreGPIO IO_NUM.
SYNC_STAGES, 2, synchroniser flop depth (2..4).
TICK_DIV, 1000, PCLK cycles per debounce tick (1..65535); a value of 1 gives a tick every cycle.
DEB_TICKS, 8, consecutive mismatching ticks required to accept a new level (1..255).
INIT_VAL, 0, IO_NUM-bit reset value of the synchroniser flops and GPIO_DB; suppresses spurious edges on pulled-up inputs.

Ports:
PCLK  in  1  system clock; all logic on rising edge.
PRESET  in  1  reset, synchronous, active-high.
EN  in  1  debounce enable; when low, outputs freeze.
PAD_IN  in  IO_NUM  raw asynchronous pad levels.
GPIO_DB  out  IO_NUM  debounced stable level; connects to CoreGPIO GPIO_IN.
RISE  out  IO_NUM  one-cycle pulse when GPIO_DB[i] goes 0->1.
FALL  out  IO_NUM  one-cycle pulse when GPIO_DB[i] goes 1->0.
CHANGED  out  1  OR of RISE|FALL, registered in the same cycle as the pulses.

Behaviour:
- Clock and reset: one clock, PCLK. PRESET is synchronous and active-high.
- Reset values: GPIO_DB=INIT_VAL, synchroniser flops=INIT_VAL, RISE=0, FALL=0, CHANGED=0, prescaler=0, all bit counters=0.
- Reset mid-operation: PRESET applies the reset values on the next edge and discards any count in progress.
- Synchroniser: the SYNC_STAGES-deep chain per bit always runs, including when EN=0. Its output is s[i].
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - With EN=0 the prescaler is held at 0 and tick=0.
- Per-bit counter cnt[i], width clog2(DEB_TICKS+1):
  - If s[i]==GPIO_DB[i]: cnt<=0. A glitch that returns before acceptance is discarded silently.
  - Else if tick and cnt==DEB_TICKS-1: GPIO_DB[i]<=s[i], cnt<=0, and RISE[i] or FALL[i]<=1 for one cycle.
  - Else if tick: cnt<=cnt+1.
  - The counter never exceeds DEB_TICKS-1 and never wraps.
- EN=0: all cnt[i] cleared, GPIO_DB held, RISE/FALL/CHANGED=0. On re-enable a full DEB_TICKS debounce is required again.
- Latency: a pad change at cycle 0 that is held reaches GPIO_DB between cycle SYNC_STAGES+(DEB_TICKS-1)*TICK_DIV+1 and cycle SYNC_STAGES+DEB_TICKS*TICK_DIV, depending on prescaler phase.
- Independent bits: bits are independent. Any number may update in the same cycle; RISE and FALL may both be non-zero on different bits in that cycle, with CHANGED=1.
- Pulse timing: RISE/FALL are registered and asserted in the same cycle GPIO_DB changes. They are never held for more than one cycle, because a new acceptance needs at least one more tick.
- Design rule: no combinational path from PAD_IN to any output.

Decomposition:
- Shared package/include gpio_in_debounce_pkg:
  - clog2 function.
  - Localparams CNT_W=clog2(DEB_TICKS+1) and PRE_W=clog2(TICK_DIV).
- Top level contains the prescaler, the generate loop and the CHANGED OR-reduction.
- One sub-module, gpio_db_bit: synchroniser, counter, level register and edge pulses for a single bit. It takes the tick and EN as inputs and is instantiated IO_NUM times.

Test Plan:
Bench configuration: IO_NUM=4, SYNC_STAGES=2, TICK_DIV=4, DEB_TICKS=3, INIT_VAL=4'b1000.
1. Reset, PAD_IN=4'b1000 held 40 cycles -> GPIO_DB=4'b1000 throughout; RISE, FALL and CHANGED never assert.
2. PAD_IN[0] 0->1 at cycle 0 and held -> GPIO_DB[0]=1 at some cycle in 11..14. RISE[0] and CHANGED are high for exactly that one cycle; other bits unchanged.
3. PAD_IN[1] high for 6 cycles, then low -> GPIO_DB[1] stays 0 and no pulses. Repeat with a 20-cycle hold -> one RISE[1], then after release one FALL[1] 11..14 cycles later.
4. PAD_IN 4'b1000->4'b0101 in one cycle -> GPIO_DB=4'b0101 in a single cycle, with RISE=4'b0101, FALL=4'b1000 and CHANGED=1 together.
5. PAD_IN[2] rises; EN dropped 6 cycles later for 10 cycles, then raised -> GPIO_DB[2] stays 0 while EN=0. It goes to 1 within 11..14 cycles of EN=1 (SYNC_STAGES does not apply, already synced).
6. PRESET pulsed for 1 cycle while cnt[3] is mid-count -> next cycle GPIO_DB=4'b1000 and all pulses 0. A held change is then accepted only after a full 11..14-cycle debounce.
